// File: rtl/sum_req_issuer_pkg.sv
// sum_req_issuer_pkg: shared state encoding and operand-pair record for the adder request issuer.
package sum_req_issuer_pkg;
  localparam int SUM_W = 20;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} issuer_state_t;
  typedef struct packed {
    logic [SUM_W-1:0] a;
    logic [SUM_W-1:0] b;
  } operand_pair_t;
endpackage

// File: rtl/sum_req_fifo.sv
// sum_req_fifo: synchronous FIFO of operand pairs with count-based full/empty and a registered-head read port.
module sum_req_fifo
  import sum_req_issuer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = operand_pair_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  T              mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_q] <= din_i;
  end
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem[rd_q];
endmodule

// File: rtl/sum_req_issuer.sv
// sum_req_issuer: buffers operand pairs, issues one start/a/b request at a time and returns the adder sum downstream.
// Define SUM_REQ_ISSUER_TIMEOUT_EN to add a WAIT-state watchdog that reports a missing adder response via res_err.
module sum_req_issuer
  import sum_req_issuer_pkg::*;
#(
  parameter int W       = 20,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic         valid,
  input  logic [W-1:0] y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_err
);
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;
  pair_t         head, din;
  logic          full, empty, pop;
  issuer_state_t state_q;
  assign in_ready = !full;
  assign din      = pair_t'{a: in_a, b: in_b};
  assign pop      = state_q == IDLE && !empty && !res_valid;
  sum_req_fifo #(.DEPTH(DEPTH), .T(pair_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .pop_i   (pop),
    .din_i   (din),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );
`ifdef SUM_REQ_ISSUER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  assign cnt_d = cnt_q + 1'b1;
`else
  assign res_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start     <= 1'b0;
      a         <= '0;
      b         <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
`ifdef SUM_REQ_ISSUER_TIMEOUT_EN
      res_err   <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          start <= pop;
          if (pop) begin
            a       <= head.a;
            b       <= head.b;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          start <= 1'b0;
          if (valid) begin
            res_sum   <= y;
            res_valid <= 1'b1;
            state_q   <= HOLD;
`ifdef SUM_REQ_ISSUER_TIMEOUT_EN
            res_err   <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_d == CW'(TIMEOUT)) begin
            res_sum   <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state_q   <= HOLD;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_d;
`endif
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_req_issuer.sv
// tb_sum_req_issuer: directed vector bench with a one-cycle-latency adder model; honours SUM_REQ_ISSUER_TIMEOUT_EN.
module tb_sum_req_issuer;
  localparam int W = 20;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         err;
  } vec_t;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         start;
  logic [W-1:0] a, b;
  logic         valid = 1'b0;
  logic [W-1:0] y = '0;
  logic         res_valid, res_ready = 1'b0, res_err;
  logic [W-1:0] res_sum;
  logic         adder_en = 1'b1;
  int           n_chk = 0, n_err = 0, cyc = 0, last_start = -100;
  logic         prev_start = 1'b0;
  logic [2*W-1:0] exp_q [$];
  vec_t         vecs [8];
  vec_t         bps  [5];

  sum_req_issuer #(.W(W), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .y         (y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Adder model: samples start, answers on the following edge.
  always @(posedge clk) begin
    valid <= adder_en && start;
    y     <= a + b;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue monitor: pulse width, spacing and issue order against accepted pushes.
  always @(negedge clk) begin
    if (rst_n && start) begin
      logic [2*W-1:0] p;
      check("start_1cyc", prev_start, 0);
      check("start_gap", (cyc - last_start) >= 4, 1);
      check("issue_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("issue_a", a, p[2*W-1:W]);
        check("issue_b", b, p[W-1:0]);
      end
      last_start = cyc;
    end
    prev_start = rst_n && start;
  end

  task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = pa;
    in_b     = pb;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk);
    exp_q.push_back({pa, pb});
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [W-1:0] es, input logic ee);
    int k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, res_valid, 1);
    check({name, "_sum"}, res_sum, es);
    check({name, "_err"}, res_err, ee);
    @(negedge clk);
  endtask

  initial begin
    int k, seen;
    vecs[0] = '{20'h00123, 20'h00045, 20'h00168, 1'b0};
    vecs[1] = '{20'hFFFFF, 20'h00001, 20'h00000, 1'b0};
    vecs[2] = '{20'h12345, 20'h54321, 20'h66666, 1'b0};
    vecs[3] = '{20'h80000, 20'h80000, 20'h00000, 1'b0};
    vecs[4] = '{20'h7FFFF, 20'h00001, 20'h80000, 1'b0};
    vecs[5] = '{20'h00000, 20'h00000, 20'h00000, 1'b0};
    vecs[6] = '{20'hABCDE, 20'h11111, 20'hBCDEF, 1'b0};
    vecs[7] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFE, 1'b0};
    bps[0]  = '{20'h00001, 20'h00002, 20'h00003, 1'b0};
    bps[1]  = '{20'h00010, 20'h00020, 20'h00030, 1'b0};
    bps[2]  = '{20'h00100, 20'h00200, 20'h00300, 1'b0};
    bps[3]  = '{20'h01000, 20'h02000, 20'h03000, 1'b0};
    bps[4]  = '{20'h10000, 20'h20000, 20'h30000, 1'b0};
    repeat (2) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_res_err", res_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].a, vecs[i].b);
      wait_res($sformatf("vec%0d", i), vecs[i].sum, vecs[i].err);
    end
    // Second push lands on the issue edge of the first.
    push(20'h00AAA, 20'h00111);
    push(20'h00BBB, 20'h00222);
    wait_res("pp0", 20'h00BBB, 1'b0);
    wait_res("pp1", 20'h00DDD, 1'b0);
    repeat (8) @(negedge clk);
    check("pp_no_extra", res_valid, 0);
    check("pp_all_issued", exp_q.size(), 0);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(bps[i].a, bps[i].b);
    @(negedge clk);
    check("bp_full", in_ready, 0);
    check("bp_held_res", res_valid, 1);
    in_valid = 1'b1;
    in_a     = 20'h0DEAD;
    in_b     = 20'h0BEEF;
    seen     = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(in_ready);
    end
    in_valid = 1'b0;
    check("bp_stall", seen, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_res($sformatf("bp%0d", i), bps[i].sum, bps[i].err);
    push(20'h00777, 20'h00111);
    k = 0;
    while (!start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rw_start_seen", start, 1);
    @(posedge clk);
    #1;
    check("rw_adder_valid", valid, 1);
    rst_n = 1'b0;
    #1;
    check("rw_start", start, 0);
    check("rw_res_valid", res_valid, 0);
    check("rw_in_ready", in_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(res_valid) + int'(start);
    end
    check("rw_late_ignored", seen, 0);
    push(20'h00005, 20'h00006);
    wait_res("post_rst", 20'h0000B, 1'b0);
    adder_en = 1'b0;
    push(20'h00001, 20'h00002);
`ifdef SUM_REQ_ISSUER_TIMEOUT_EN
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("to_valid", res_valid, 1);
    check("to_latency", cyc - last_start, 8);
    check("to_sum", res_sum, 0);
    check("to_err", res_err, 1);
    @(negedge clk);
    check("to_released", res_valid, 0);
`else
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen += int'(res_valid);
    end
    check("noto_wait", seen, 0);
    check("noto_err", res_err, 0);
`endif
    adder_en = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sum_req_issuer.md
Name: sum_req_issuer

Overview:
- Initiator side of the start/a/b -> valid/y adder handshake.
- Accepts operand pairs from upstream over valid/ready and buffers them in a small FIFO.
- Issues one start pulse per pair to the adder and holds a/b stable until the adder's valid.
- Captures y and presents it downstream over valid/ready; an optional watchdog flags an adder that never responds.

Parameters:
- W, 20, operand and sum width in bits.
- DEPTH, 4, operand FIFO entries; power of 2, minimum 2.
- TIMEOUT, 8, WAIT cycles without adder valid before error (watchdog build only); minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- start  output  1  single-cycle request pulse to adder.
- a  output  W  operand a to adder.
- b  output  W  operand b to adder.
- valid  input  1  adder result valid.
- y  input  W  adder sum.
- res_valid  output  1  result available downstream.
- res_ready  input  1  downstream accepts result.
- res_sum  output  W  captured sum.
- res_err  output  1  result produced by timeout, not by adder.

Behaviour:
- Reset (async, rst_n low): FIFO emptied; state IDLE; start=0, a=0, b=0, res_valid=0, res_sum=0, res_err=0, timeout counter 0.
- Reset mid-operation discards all buffered and in-flight pairs. A valid arriving after reset release is ignored in IDLE.
- All outputs are registered except in_ready, which is combinational from the FIFO count.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only on issue.
  - Push and pop in the same cycle are allowed and leave the count unchanged.
  - When full, in_ready=0 and a presented pair is held upstream, not dropped.
  - Pointers wrap modulo DEPTH.
- State IDLE:
  - If FIFO not empty and res_valid==0: register start<=1, a<=head.a, b<=head.b, pop, go WAIT.
  - Otherwise start<=0.
  - An adder valid seen in IDLE or HOLD is ignored.
- State WAIT:
  - start<=0 (pulse is exactly 1 cycle). a and b hold their values.
  - On valid==1: res_sum<=y, res_err<=0, res_valid<=1, go HOLD.
  - With a correct adder, valid is sampled 2 edges after the edge that set start.
- State HOLD:
  - res_valid stays 1; res_sum and res_err are stable.
  - On res_ready: res_valid<=0, go IDLE.
  - res_ready while res_valid==0 has no effect.
- Throughput is 1 op per 4 cycles minimum (IDLE, WAIT, WAIT, HOLD) when res_ready is held high. Only one request is outstanding at a time.
- Arithmetic: none internal. res_sum is y verbatim (mod 2^W as produced by the adder).

Optional Feature:
- Macro: SUM_REQ_ISSUER_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles from 1.
  - If the count reaches TIMEOUT with no valid: res_sum<=0, res_err<=1, res_valid<=1, go HOLD.
  - Counter clears on leaving WAIT.
  - If valid arrives in the same cycle the count reaches TIMEOUT, valid wins (res_err=0).
- Undefined: WAIT waits indefinitely; res_err is constant 0; no counter is synthesised.

Decomposition:
- Package sum_req_issuer_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, HOLD} issuer_state_t;
  - typedef struct packed operand_pair_t {a, b} parameterised via W, with default localparam SUM_W=20.
- Sub-module sum_req_fifo: synchronous FIFO of operand_pair_t with DEPTH entries. It exposes full, empty and head, and uses async active-low reset on rst_n.

Test Plan:
- Single op: push a=0x00123, b=0x00045, res_ready=1 -> start high exactly 1 cycle with a/b matching; res_valid with res_sum=0x00168, res_err=0; FSM back in IDLE.
- Wrap-around: a=0xFFFFF, b=0x00001 -> res_sum=0x00000, res_err=0.
- Back-pressure: push 5 pairs with res_ready=0 -> 1 issued, 4 buffered, in_ready=0 after FIFO full. Raise res_ready -> 5 results in push order, with start pulses at least 4 cycles apart.
- Simultaneous push/pop: FIFO count=1 and a new push in the issue cycle -> count stays 1; no pair lost or duplicated.
- Reset mid-WAIT: assert rst_n low between start and valid -> start, res_valid and in_ready-blocking all clear; the late adder valid produces no result.
- Timeout (macro defined, adder valid stuck 0): issue a=1, b=2 -> after 8 WAIT cycles res_valid=1, res_err=1, res_sum=0. Macro undefined -> res_valid stays 0 indefinitely.
